// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_seq
//  Description : Registered ALU control sequencer. Accepts ALUop/funct/t0/t1
//                requests over a valid/ready handshake and presents the
//                decoded ALU control code one cycle later. Shift ops are
//                issued as a train of 1-bit shift micro-ops, repeated
//                iter_cnt times, one per cycle.
//  Ports       : clk, rst_n (sync, active-low)
//                in_valid/in_ready          request handshake
//                alu_op, funct, t0, t1      operation selection
//                iter_cnt                   shift repeat count (at accept)
//                out_valid, ctrl_bits       micro-op beat and its code
//                ctrl_last                  final beat of the request
//                illegal                    beat comes from an undefined op
//                busy                       more shift beats still pending
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq #(
    parameter int ALUOP_W = 3,
    parameter int CTRL_W  = 3,
    parameter int CNT_W   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ALUOP_W-1:0] alu_op,
    input  logic               funct,
    input  logic               t0,
    input  logic               t1,
    input  logic [CNT_W-1:0]   iter_cnt,
    output logic               out_valid,
    output logic [CTRL_W-1:0]  ctrl_bits,
    output logic               ctrl_last,
    output logic               illegal,
    output logic               busy
);

    localparam logic [2:0] c_ADD = 3'b000;
    localparam logic [2:0] c_SUB = 3'b001;
    localparam logic [2:0] c_AND = 3'b010;
    localparam logic [2:0] c_OR  = 3'b011;
    localparam logic [2:0] c_SLL = 3'b100;
    localparam logic [2:0] c_SRL = 3'b101;
    localparam logic [2:0] c_SLT = 3'b110;
    localparam logic [2:0] c_NOP = 3'b111;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_REPEAT = 1'b1
    } state_t;

    state_t             r_state;
    logic [2:0]         r_code;
    logic [CNT_W-1:0]   r_remain;   // beats still to be emitted after the current one
    logic               r_out_valid;
    logic               r_last;
    logic               r_illegal;

    logic               w_hi_bad;
    logic [2:0]         w_code;
    logic               w_illegal;
    logic               w_shift;
    logic               w_accept;

    // Any set opcode bit above [2:0] makes the request illegal.
    generate
        if (ALUOP_W > 3) begin : g_hi_chk
            assign w_hi_bad = |alu_op[ALUOP_W-1:3];
        end else begin : g_hi_none
            assign w_hi_bad = 1'b0;
        end
    endgenerate

    always_comb begin
        w_code    = c_NOP;
        w_illegal = 1'b0;
        w_shift   = 1'b0;
        if (w_hi_bad) begin
            w_illegal = 1'b1;
        end else begin
            case (alu_op[2:0])
                3'b000:  w_code = c_ADD;
                3'b001:  w_code = c_SUB;
                3'b010:  w_code = funct ? c_SUB : c_ADD;
                3'b011:  w_code = funct ? c_OR  : c_AND;
                3'b100: begin
                    w_code  = funct ? c_SRL : c_SLL;
                    w_shift = 1'b1;
                end
                3'b101:  w_code = c_SLT;
                3'b110: begin
                    case ({t1, t0})
                        2'b00:   w_code = c_ADD;
                        2'b01:   w_code = c_SUB;
                        2'b10:   w_code = c_AND;
                        default: w_code = c_OR;
                    endcase
                end
                default: w_illegal = 1'b1;
            endcase
        end
    end

    // REPEAT is left on the cycle the last beat is presented, so a new
    // request can be taken on that beat without a bubble.
    assign in_ready = rst_n && (r_state == S_IDLE);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_code      <= c_NOP;
            r_remain    <= '0;
            r_out_valid <= 1'b0;
            r_last      <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_illegal   <= w_illegal;
            if (w_shift && (iter_cnt == c_CNT_ZERO)) begin
                // Zero-length shift degenerates to a single legal NOP beat.
                r_code  <= c_NOP;
                r_last  <= 1'b1;
                r_state <= S_IDLE;
            end else if (w_shift && (iter_cnt > c_CNT_ONE)) begin
                r_code   <= w_code;
                r_last   <= 1'b0;
                r_remain <= iter_cnt - c_CNT_ONE;
                r_state  <= S_REPEAT;
            end else begin
                r_code  <= w_code;
                r_last  <= 1'b1;
                r_state <= S_IDLE;
            end
        end else if (r_state == S_REPEAT) begin
            // r_code holds the latched shift code for the whole train.
            r_out_valid <= 1'b1;
            r_illegal   <= 1'b0;
            r_remain    <= r_remain - c_CNT_ONE;
            if (r_remain == c_CNT_ONE) begin
                r_last  <= 1'b1;
                r_state <= S_IDLE;
            end else begin
                r_last  <= 1'b0;
            end
        end else begin
            r_out_valid <= 1'b0;
            r_code      <= c_NOP;
            r_last      <= 1'b0;
            r_illegal   <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign ctrl_last = r_last;
    assign illegal   = r_illegal;
    assign busy      = (r_state == S_REPEAT);

    generate
        if (CTRL_W > 3) begin : g_ctrl_wide
            assign ctrl_bits = {{(CTRL_W-3){1'b0}}, r_code};
        end else begin : g_ctrl_exact
            assign ctrl_bits = r_code;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_seq
//  Description : Scoreboard bench for alu_ctrl_seq. The driver predicts each
//                request's beat train (cycle, code, last, illegal, busy) and
//                queues it; a negedge monitor pops and compares every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    localparam int ALUOP_W = 4;
    localparam int CTRL_W  = 4;
    localparam int CNT_W   = 4;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [ALUOP_W-1:0] alu_op;
    logic               funct;
    logic               t0;
    logic               t1;
    logic [CNT_W-1:0]   iter_cnt;
    logic               out_valid;
    logic [CTRL_W-1:0]  ctrl_bits;
    logic               ctrl_last;
    logic               illegal;
    logic               busy;

    alu_ctrl_seq #(
        .ALUOP_W (ALUOP_W),
        .CTRL_W  (CTRL_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .t0        (t0),
        .t1        (t1),
        .iter_cnt  (iter_cnt),
        .out_valid (out_valid),
        .ctrl_bits (ctrl_bits),
        .ctrl_last (ctrl_last),
        .illegal   (illegal),
        .busy      (busy)
    );

    typedef struct {
        int cyc;
        int code;
        bit last;
        bit ill;
        bit bsy;
    } beat_t;

    beat_t exp_q[$];
    int    cyc       = 0;
    int    last_beat = 0;
    int    n_tests   = 0;
    int    n_fail    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: op -> (code, illegal, beat count) straight from the opcode table.
    task automatic model_push(input int op, input bit f, input bit tt1,
                              input bit tt0, input int k, input int c);
        int code;
        bit ill;
        int n;
        ill = 1'b0;
        n   = 1;
        if (op > 7) begin
            code = 7;
            ill  = 1'b1;
        end else begin
            case (op)
                0: code = 0;
                1: code = 1;
                2: code = f ? 1 : 0;
                3: code = f ? 3 : 2;
                4: begin
                    code = f ? 5 : 4;
                    if (k == 0) code = 7;
                    else        n    = k;
                end
                5: code = 6;
                6: code = tt1 * 2 + tt0;
                default: begin
                    code = 7;
                    ill  = 1'b1;
                end
            endcase
        end
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.cyc  = c + 1 + i;
            b.code = code;
            b.last = (i == n - 1);
            b.ill  = ill;
            b.bsy  = (i < n - 1);
            exp_q.push_back(b);
        end
        last_beat = c + n;
    endtask

    // One clock cycle of stimulus; acc reports whether the model saw an accept.
    task automatic step(input bit v, input int op, input bit f, input bit tt1,
                        input bit tt0, input int k, input bit rn, output bit acc);
        bit exp_ready;
        @(posedge clk);
        #1;
        rst_n    = rn;
        in_valid = v;
        alu_op   = op[ALUOP_W-1:0];
        funct    = f;
        t1       = tt1;
        t0       = tt0;
        iter_cnt = k[CNT_W-1:0];
        #6;
        exp_ready = rn && (cyc >= last_beat);
        n_tests++;
        if (in_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready);
        end
        acc = v && exp_ready;
        if (!rn) begin
            while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
            last_beat = 0;
        end
        if (acc) model_push(op, f, tt1, tt0, k, cyc);
    endtask

    task automatic send(input int op, input bit f, input bit tt1, input bit tt0,
                        input int k);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 40) begin
            step(1'b1, op, f, tt1, tt0, k, 1'b1, acc);
            tries++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout op=%0d got=not_accepted exp=accepted", op);
        end
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, acc);
    endtask

    // Monitor: every cycle the DUT must present exactly the queued beat, or nothing.
    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 2) begin
                while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL missed_beat cyc=%0d got=none exp_cyc=%0d", cyc, exp_q[0].cyc);
                    void'(exp_q.pop_front());
                end
                n_tests++;
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (out_valid !== 1'b1 || ctrl_bits !== CTRL_W'(e.code) ||
                        ctrl_last !== e.last || illegal !== e.ill || busy !== e.bsy) begin
                        n_fail++;
                        $display("FAIL beat cyc=%0d got v=%b code=%b last=%b ill=%b busy=%b exp v=1 code=%0d last=%b ill=%b busy=%b",
                                 cyc, out_valid, ctrl_bits, ctrl_last, illegal, busy,
                                 e.code, e.last, e.ill, e.bsy);
                    end
                end else begin
                    if (out_valid !== 1'b0 || ctrl_bits !== CTRL_W'(7) ||
                        ctrl_last !== 1'b0 || illegal !== 1'b0 || busy !== 1'b0) begin
                        n_fail++;
                        $display("FAIL idle cyc=%0d got v=%b code=%b last=%b ill=%b busy=%b exp v=0 code=0111 last=0 ill=0 busy=0",
                                 cyc, out_valid, ctrl_bits, ctrl_last, illegal, busy);
                    end
                end
            end
        end
    end

    initial begin
        bit acc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        alu_op   = '0;
        funct    = 1'b0;
        t0       = 1'b0;
        t1       = 1'b0;
        iter_cnt = '0;

        // Reset, then idle.
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, acc);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, acc);
        idle(2);

        // Single ops back-to-back.
        send(6, 1'b0, 1'b1, 1'b1, 0);
        send(2, 1'b1, 1'b0, 1'b0, 0);
        idle(1);

        // Shift x5 with a follow-on request taken on the last beat.
        send(4, 1'b1, 1'b0, 1'b0, 5);
        send(3, 1'b1, 1'b0, 1'b0, 0);
        idle(1);

        // Illegal ops and zero-count shift.
        send(7, 1'b0, 1'b0, 1'b0, 0);
        send(12, 1'b1, 1'b1, 1'b0, 3);
        send(4, 1'b0, 1'b0, 1'b0, 0);
        send(4, 1'b1, 1'b0, 1'b0, 1);
        idle(1);

        // Reset on beat 3 of a 7-beat shift.
        send(4, 1'b0, 1'b0, 1'b0, 7);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, acc);
        step(1'b1, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, acc);
        step(1'b1, 1, 1'b0, 1'b0, 1'b0, 0, 1'b0, acc);
        idle(10);

        // Maximum counts.
        send(4, 1'b1, 1'b0, 1'b0, 7);
        send(4, 1'b0, 1'b0, 1'b0, 15);
        idle(3);

        // Randomised traffic, including occasional resets.
        for (int i = 0; i < 400; i++) begin
            int op;
            int k;
            bit v;
            bit rn;
            v  = ($urandom_range(0, 2) != 0);
            op = $urandom_range(0, 15);
            if ($urandom_range(0, 2) == 0) op = 4;
            k  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
            rn = ($urandom_range(0, 79) != 0);
            step(v, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), k, rn, acc);
        end

        idle(20);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d_pending exp=0_pending", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
